usb_rx_bit_decoder: RTL

- Receive-side bit layer for the USB transceiver. It combines three functions in one block, all advanced by the clock-recovery bit strobe:
  - NRZI decode
  - bit unstuffing with stuff-error detection
  - SE0/EOP detection
- Sits between the clock-recovery/line-sampler and the packet deserializer. It replaces the plain NRZI decoder with a packet-aware, parametrised block.

---
 rtl/usb_bit_pkg.sv | 24 ++
 rtl/usb_rx_bit_decoder_if.sv | 29 ++
 rtl/usb_rx_bit_decoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/usb_bit_pkg.sv
// Shared definitions for the USB receive bit layer.
//   rx_bit_state_t   : state of the receive bit decoder
//   J_LEVEL/K_LEVEL  : default line_bit encodings of the J (idle) and K states
//   IDLE_TIMEOUT     : J samples in a row that release the decoder from ERROR
//   is_j()           : true when a line sample equals the idle (J) level
package usb_bit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        SE0_RUN,
        ERROR
    } rx_bit_state_t;

    localparam logic J_LEVEL = 1'b1;
    localparam logic K_LEVEL = ~J_LEVEL;

    localparam int IDLE_TIMEOUT = 8;

    function automatic logic is_j(input logic line_bit, input logic idle_level);
        return line_bit == idle_level;
    endfunction

endpackage

// File: rtl/usb_rx_bit_decoder_if.sv
// Bit-level link between the line sampler and the receive bit decoder.
//   en, sample_valid, line_bit, se0      : sampler side -> decoder
//   data_bit, data_valid, active, eop,
//   stuff_err, eop_err                   : decoder -> packet deserializer
// master : the sampler/deserializer side; slave : the decoder itself.
interface usb_rx_bit_decoder_if;

    logic en;
    logic sample_valid;
    logic line_bit;
    logic se0;
    logic data_bit;
    logic data_valid;
    logic active;
    logic eop;
    logic stuff_err;
    logic eop_err;

    modport master (
        output en, sample_valid, line_bit, se0,
        input  data_bit, data_valid, active, eop, stuff_err, eop_err
    );

    modport slave (
        input  en, sample_valid, line_bit, se0,
        output data_bit, data_valid, active, eop, stuff_err, eop_err
    );

endinterface

// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit layer: NRZI decode, bit unstuffing with stuff-error
// detection and SE0/EOP detection, all advanced by the bit strobe.
//   clk, nRST : system clock, asynchronous active-low reset
//   bus       : slave side of usb_rx_bit_decoder_if
// All outputs are registered; each response appears one clk after the
// sample_valid cycle that caused it. Pulse outputs are low otherwise.
module usb_rx_bit_decoder
    import usb_bit_pkg::*;
#(
    parameter int   STUFF_LEN    = 6,
    parameter logic IDLE_LEVEL   = J_LEVEL,
    parameter int   EOP_SE0_BITS = 2
) (
    input  logic                 clk,
    input  logic                 nRST,
    usb_rx_bit_decoder_if.slave  bus
);

    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam int SE0_W  = $clog2(EOP_SE0_BITS + 1);

    localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);
    localparam logic [SE0_W-1:0]  SE0_MAX   = SE0_W'(EOP_SE0_BITS);
    localparam logic [2:0]        IDLE_LAST = 3'(IDLE_TIMEOUT - 1);

    rx_bit_state_t     state_q, state_d;
    logic              prev_line_q, prev_line_d;
    logic [ONES_W-1:0] ones_cnt_q, ones_cnt_d;
    logic [SE0_W-1:0]  se0_cnt_q, se0_cnt_d;
    logic [2:0]        idle_cnt_q, idle_cnt_d;

    logic data_bit_q, data_bit_d;
    logic data_valid_q, data_valid_d;
    logic active_q, active_d;
    logic eop_q, eop_d;
    logic stuff_err_q, stuff_err_d;
    logic eop_err_q, eop_err_d;

    logic decoded;
    logic line_j;
    logic [SE0_W-1:0] se0_sat_inc;

    assign decoded     = (bus.line_bit == prev_line_q);
    assign line_j      = is_j(bus.line_bit, IDLE_LEVEL);
    assign se0_sat_inc = (se0_cnt_q == SE0_MAX) ? se0_cnt_q : se0_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        prev_line_d  = prev_line_q;
        ones_cnt_d   = ones_cnt_q;
        se0_cnt_d    = se0_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        data_bit_d   = 1'b0;
        data_valid_d = 1'b0;
        active_d     = active_q;
        eop_d        = 1'b0;
        stuff_err_d  = 1'b0;
        eop_err_d    = 1'b0;

        if (!bus.en) begin
            state_d     = IDLE;
            prev_line_d = IDLE_LEVEL;
            ones_cnt_d  = '0;
            se0_cnt_d   = '0;
            idle_cnt_d  = '0;
            active_d    = 1'b0;
        end else if (bus.sample_valid) begin
            // SE0 carries no differential level, so the NRZI reference holds.
            if (!bus.se0) begin
                prev_line_d = bus.line_bit;
            end

            case (state_q)
                IDLE: begin
                    // The first K is a transition from idle J: a decoded 0.
                    if (!bus.se0 && !line_j) begin
                        state_d      = ACTIVE;
                        active_d     = 1'b1;
                        data_valid_d = 1'b1;
                        data_bit_d   = 1'b0;
                        ones_cnt_d   = '0;
                    end
                end

                ACTIVE: begin
                    // SE0 wins over the stuff position: a packet may end there.
                    if (bus.se0) begin
                        state_d   = SE0_RUN;
                        se0_cnt_d = SE0_W'(1);
                    end else if (ones_cnt_q == STUFF_MAX) begin
                        if (!decoded) begin
                            ones_cnt_d = '0;
                        end else begin
                            stuff_err_d = 1'b1;
                            state_d     = ERROR;
                            se0_cnt_d   = '0;
                            idle_cnt_d  = '0;
                        end
                    end else begin
                        data_valid_d = 1'b1;
                        data_bit_d   = decoded;
                        ones_cnt_d   = decoded ? ones_cnt_q + 1'b1 : '0;
                    end
                end

                SE0_RUN: begin
                    if (bus.se0) begin
                        se0_cnt_d = se0_sat_inc;
                    end else if (line_j && se0_cnt_q == SE0_MAX) begin
                        eop_d       = 1'b1;
                        state_d     = IDLE;
                        active_d    = 1'b0;
                        prev_line_d = IDLE_LEVEL;
                        ones_cnt_d  = '0;
                        se0_cnt_d   = '0;
                    end else begin
                        eop_err_d  = 1'b1;
                        state_d    = ERROR;
                        se0_cnt_d  = '0;
                        idle_cnt_d = '0;
                    end
                end

                ERROR: begin
                    // Leave on a full EOP-shaped SE0 run plus J, or on a long J run.
                    if (bus.se0) begin
                        se0_cnt_d  = se0_sat_inc;
                        idle_cnt_d = '0;
                    end else if (line_j && (se0_cnt_q == SE0_MAX || idle_cnt_q == IDLE_LAST)) begin
                        state_d     = IDLE;
                        active_d    = 1'b0;
                        prev_line_d = IDLE_LEVEL;
                        ones_cnt_d  = '0;
                        se0_cnt_d   = '0;
                        idle_cnt_d  = '0;
                    end else if (line_j) begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                        se0_cnt_d  = '0;
                    end else begin
                        idle_cnt_d = '0;
                        se0_cnt_d  = '0;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            prev_line_q  <= IDLE_LEVEL;
            ones_cnt_q   <= '0;
            se0_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            data_bit_q   <= 1'b0;
            data_valid_q <= 1'b0;
            active_q     <= 1'b0;
            eop_q        <= 1'b0;
            stuff_err_q  <= 1'b0;
            eop_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_line_q  <= prev_line_d;
            ones_cnt_q   <= ones_cnt_d;
            se0_cnt_q    <= se0_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            data_bit_q   <= data_bit_d;
            data_valid_q <= data_valid_d;
            active_q     <= active_d;
            eop_q        <= eop_d;
            stuff_err_q  <= stuff_err_d;
            eop_err_q    <= eop_err_d;
        end
    end

    assign bus.data_bit   = data_bit_q;
    assign bus.data_valid = data_valid_q;
    assign bus.active     = active_q;
    assign bus.eop        = eop_q;
    assign bus.stuff_err  = stuff_err_q;
    assign bus.eop_err    = eop_err_q;

endmodule
